// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Measures a free-running PWM line. Every rising edge of the line closes a
//   period and reports its length (period) and its high time (duty, saturated
//   to 255). If no rising edge arrives for TIMEOUT cycles, the line is reported
//   as static: period=0, duty=255 for stuck-high or 0 for stuck-low.
//
// Parameters
//   TIMEOUT     cycles without a rising edge before a static result (2..511)
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   reset       asynchronous, active-high reset
//   pwm_in      asynchronous PWM line being measured
//   duty        high time of the last measured period, saturated to 255
//   period      rising-edge-to-rising-edge time; 0 on a static result
//   static_out  1 = last result was a timeout, 0 = a real period
//   valid       one-cycle pulse when duty/period/static_out update
module pwm_decoder #(
  parameter int unsigned TIMEOUT = 511
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] duty,
  output logic [8:0] period,
  output logic       static_out,
  output logic       valid
);

  localparam logic [8:0] CNT_MAX = '1;
  localparam logic [8:0] TO_VAL  = 9'(TIMEOUT);

  typedef enum logic {
    IDLE,     // no reference edge captured yet
    MEASURE   // reference edge captured, counting the current period
  } state_e;

  // Input synchronizer (s1, s2) plus one delayed copy (s3) for edge detect
  logic s1_q, s2_q, s3_q;
  logic rise;

  state_e     state_q, state_d;
  logic [8:0] pcnt_q, pcnt_d;
  logic [8:0] hcnt_q, hcnt_d;
  logic [7:0] duty_q, duty_d;
  logic [8:0] period_q, period_d;
  logic       static_q, static_d;
  logic       valid_q, valid_d;

  logic [8:0] pcnt_inc;
  logic [8:0] hcnt_inc;
  logic       timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Both counters saturate rather than wrap
  assign pcnt_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 9'd1;
  assign hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 9'd1;

  // pcnt never skips past TIMEOUT (it reloads to 0/1 and steps by one), so
  // >= behaves as == here but stays safe against any stray value.
  assign timeout = (pcnt_q >= TO_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      static_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      static_q <= static_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    duty_d   = duty_q;
    period_d = period_q;
    static_d = static_q;
    valid_d  = 1'b0;

    // A rise takes priority over a simultaneous timeout.
    if (rise) begin
      if (state_q == MEASURE) begin
        period_d = pcnt_q;
        duty_d   = (hcnt_q > 9'd255) ? 8'd255 : hcnt_q[7:0];
        static_d = 1'b0;
        valid_d  = 1'b1;
      end
      // The rise cycle itself is the first cycle of the new period and is high
      state_d = MEASURE;
      pcnt_d  = 9'd1;
      hcnt_d  = 9'd1;
    end else if (timeout) begin
      period_d = '0;
      duty_d   = s2_q ? 8'd255 : 8'd0;
      static_d = 1'b1;
      valid_d  = 1'b1;
      state_d  = IDLE;
      pcnt_d   = '0;
      hcnt_d   = '0;
    end else begin
      pcnt_d = pcnt_inc;
      case (state_q)
        IDLE:    hcnt_d = '0;
        MEASURE: hcnt_d = s2_q ? hcnt_inc : hcnt_q;
        default: hcnt_d = '0;
      endcase
    end
  end

  assign duty       = duty_q;
  assign period     = period_q;
  assign static_out = static_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_pwm_decoder.sv
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] duty_a, duty_b;
  logic [8:0] period_a, period_b;
  logic       static_a, static_b, valid_a, valid_b;

  pwm_decoder #(.TIMEOUT(511)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .duty(duty_a), .period(period_a), .static_out(static_a), .valid(valid_a)
  );

  pwm_decoder #(.TIMEOUT(256)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .duty(duty_b), .period(period_b), .static_out(static_b), .valid(valid_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse (sampled on the falling edge)
  int         a_vcnt = 0;
  int         a_vt[128];
  logic [7:0] a_duty = '0;
  logic [8:0] a_period = '0;
  logic       a_static = 1'b0;
  int         b_vcnt = 0;
  int         b_scnt = 0;
  logic [7:0] b_duty = '0;
  logic [8:0] b_period = '0;

  always @(negedge clk) begin
    if (valid_a) begin
      if (a_vcnt < 128) a_vt[a_vcnt] <= cyc;
      a_vcnt   <= a_vcnt + 1;
      a_duty   <= duty_a;
      a_period <= period_a;
      a_static <= static_a;
    end
    if (valid_b) begin
      b_vcnt   <= b_vcnt + 1;
      b_duty   <= duty_b;
      b_period <= period_b;
      if (static_b) b_scnt <= b_scnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int base, bbase, sbase, t_rel;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Asynchronous reset with no clock edge yet
    #1 reset = 1'b1;
    #1;
    check("rst_duty",   int'(duty_a),   0);
    check("rst_period", int'(period_a), 0);
    check("rst_static", int'(static_a), 0);
    check("rst_valid",  int'(valid_a),  0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 100 high / 156 low, repeating
    base = a_vcnt;
    drive(1'b1, 100);
    check("first_rise_no_valid", a_vcnt - base, 0);
    drive(1'b0, 156);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 100);
      drive(1'b0, 156);
    end
    check("p256_count",  a_vcnt - base, 3);
    check("p256_duty",   int'(a_duty),   100);
    check("p256_period", int'(a_period), 256);
    check("p256_static", int'(a_static), 0);

    // 300 high / 100 low: duty saturates
    base = a_vcnt;
    drive(1'b1, 300);
    check("p400_prev_count",  a_vcnt - base, 1);
    check("p400_prev_period", int'(a_period), 256);
    drive(1'b0, 100);
    drive(1'b1, 300);
    check("p400_count",  a_vcnt - base, 2);
    check("p400_duty",   int'(a_duty),   255);
    check("p400_period", int'(a_period), 400);
    check("p400_static", int'(a_static), 0);
    drive(1'b0, 100);

    // Held high after a real period
    base = a_vcnt;
    drive(1'b1, 1100);
    check("hi_count",     a_vcnt - base, 3);
    check("hi_duty",      int'(a_duty),   255);
    check("hi_period",    int'(a_period), 0);
    check("hi_static",    int'(a_static), 1);
    check("hi_first_gap", a_vt[base + 1] - a_vt[base], 511);
    check("hi_repeat",    a_vt[base + 2] - a_vt[base + 1], 512);

    // Held low from reset
    do_reset(3);
    t_rel = cyc;
    base  = a_vcnt;
    drive(1'b0, 1600);
    check("lo_count",   a_vcnt - base, 3);
    check("lo_first",   a_vt[base] - t_rel, 512);
    check("lo_repeat",  a_vt[base + 2] - a_vt[base + 1], 512);
    check("lo_duty",    int'(a_duty),   0);
    check("lo_period",  int'(a_period), 0);
    check("lo_static",  int'(a_static), 1);

    // Reset in the middle of a measurement
    do_reset(3);
    base = a_vcnt;
    drive(1'b1, 100);
    drive(1'b0, 156);
    drive(1'b1, 100);
    drive(1'b0, 156);
    check("mid_pre_count", a_vcnt - base, 1);
    drive(1'b1, 50);
    reset  = 1'b1;
    pwm_in = 1'b0;
    #1;
    check("mid_rst_duty",   int'(duty_a),   0);
    check("mid_rst_period", int'(period_a), 0);
    check("mid_rst_static", int'(static_a), 0);
    check("mid_rst_valid",  int'(valid_a),  0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    base = a_vcnt;
    drive(1'b0, 100);
    drive(1'b1, 100);
    drive(1'b0, 156);
    check("mid_rearm_no_valid", a_vcnt - base, 0);
    drive(1'b1, 100);
    drive(1'b0, 156);
    check("mid_count",  a_vcnt - base, 1);
    check("mid_duty",   int'(a_duty),   100);
    check("mid_period", int'(a_period), 256);
    check("mid_static", int'(a_static), 0);

    // TIMEOUT=256 with a period of exactly 256: the rise must win
    do_reset(3);
    bbase = b_vcnt;
    sbase = b_scnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 100);
      drive(1'b0, 156);
    end
    check("t256_count",  b_vcnt - bbase, 4);
    check("t256_static", b_scnt - sbase, 0);
    check("t256_duty",   int'(b_duty),   100);
    check("t256_period", int'(b_period), 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
